// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl - pipeline sequencing controller for the 5-stage core.
//
// Decodes the instruction sitting in ID, compares its source registers against
// a 3-entry scoreboard of in-flight destinations (EX, MEM, WB) and produces the
// hold / bubble / flush controls for IF, IF/ID and ID/EX. Also sequences HALT:
// RUN -> DRAIN (wait for in-flight writers to retire) -> HALTED.
//
// Build option: define HAZARD_FWD_EN when the datapath has EX/MEM forwarding.
// Only a load in EX (load-use) then stalls. Undefined: any valid EX/MEM/WB
// destination match stalls.
//
// Ports:
//   clk               in   core clock
//   reset             in   synchronous, active-low reset
//   inst_f_if         in   instruction in IF/ID (decoded in ID this cycle)
//   inst_valid_f_if   in   inst_f_if is a real instruction
//   branch_taken_f_ex in   branch/JR in EX resolved taken this cycle
//   pc_hold_2_if      out  PC does not advance
//   ifid_hold_2_if    out  IF/ID keeps its contents
//   flush_2_if        out  IF/ID loads a bubble
//   bubble_2_ex       out  ID/EX loads NOP control
//   halted            out  core halted, pipeline empty
//   stall_cnt         out  saturating count of RAW stall cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int CNT_W  = 16,
   parameter int NREG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      inst_f_if,
   input  logic             inst_valid_f_if,
   input  logic             branch_taken_f_ex,
   output logic             pc_hold_2_if,
   output logic             ifid_hold_2_if,
   output logic             flush_2_if,
   output logic             bubble_2_ex,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

   typedef struct packed {
      logic              vld;
      logic [NREG_W-1:0] dst;
      logic              ld;
   } sb_t;

   state_t     state_q, state_d;
   sb_t        ex_q, mem_q, wb_q;
   sb_t        ex_d, mem_d, wb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [5:0]        op;
   logic [NREG_W-1:0] rs, rt, rd, dst;
   logic              use_rs, use_rt, has_dst, is_ld, is_halt;
   logic              rs_v, rt_v, dst_v;
   logic              raw_hit, stall, issue, in_run;

   logic unused_inst_bits;
   assign unused_inst_bits = ^inst_f_if[10:0];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic src_hit(input sb_t e, input logic [NREG_W-1:0] a,
                                    input logic av, input logic [NREG_W-1:0] b,
                                    input logic bv);
      return e.vld & ((av & (e.dst == a)) | (bv & (e.dst == b)));
   endfunction

   // Instruction decode
   always_comb begin
      op      = inst_f_if[31:26];
      rs      = inst_f_if[21 +: NREG_W];
      rt      = inst_f_if[16 +: NREG_W];
      rd      = inst_f_if[11 +: NREG_W];
      use_rs  = 1'b0;
      use_rt  = 1'b0;
      has_dst = 1'b0;
      dst     = '0;
      is_ld   = 1'b0;
      is_halt = 1'b0;
      if (op <= 6'h0B) begin
         // ALU: even = R-type (rs,rt -> rd), odd = I-type (rs -> rt)
         use_rs  = 1'b1;
         use_rt  = ~op[0];
         has_dst = 1'b1;
         dst     = op[0] ? rt : rd;
      end else begin
         case (op)
            6'h0C: begin use_rs = 1'b1; has_dst = 1'b1; dst = rt; is_ld = 1'b1; end
            6'h0D: begin use_rs = 1'b1; use_rt = 1'b1; end
            6'h0E: use_rs = 1'b1;
            6'h0F: begin use_rs = 1'b1; use_rt = 1'b1; end
            6'h10: use_rs = 1'b1;
            6'h11: is_halt = 1'b1;
            default: ;
         endcase
      end
      // r0 never creates or consumes a dependency
      rs_v  = use_rs & (rs != '0);
      rt_v  = use_rt & (rt != '0);
      dst_v = has_dst & (dst != '0);
   end

`ifdef HAZARD_FWD_EN
   logic unused_fwd_q;
   assign unused_fwd_q = ^{wb_q, mem_q.dst, mem_q.ld};
   // Forwarding covers everything except a load result still in EX.
   assign raw_hit = ex_q.ld & src_hit(ex_q, rs, rs_v, rt, rt_v);
`else
   // No forwarding: a WB write is not visible to the same-cycle ID read,
   // so all three stages are inside the window.
   assign raw_hit = src_hit(ex_q, rs, rs_v, rt, rt_v)
                  | src_hit(mem_q, rs, rs_v, rt, rt_v)
                  | src_hit(wb_q, rs, rs_v, rt, rt_v);
`endif

   // Next-state and outputs
   always_comb begin
      in_run = (state_q == RUN);
      stall  = inst_valid_f_if & in_run & raw_hit & ~branch_taken_f_ex;
      issue  = inst_valid_f_if & ~stall & ~branch_taken_f_ex & in_run;

      ex_d     = '0;
      ex_d.vld = issue & dst_v;
      ex_d.dst = ex_d.vld ? dst : '0;
      ex_d.ld  = ex_d.vld & is_ld;
      mem_d    = ex_q;
      wb_d     = mem_q;

      cnt_d   = stall ? sat_inc(cnt_q) : cnt_q;

      state_d = state_q;
      case (state_q)
         RUN:    if (issue & is_halt) state_d = DRAIN;
         // Nothing issues in DRAIN, so once EX and MEM are empty the
         // scoreboard is empty after this edge: WB retires now.
         DRAIN:  if (~ex_q.vld & ~mem_q.vld) state_d = HALTED;
         HALTED: state_d = HALTED;
         default: state_d = RUN;
      endcase

      pc_hold_2_if   = stall | ~in_run;
      ifid_hold_2_if = stall | ~in_run;
      flush_2_if     = branch_taken_f_ex;
      bubble_2_ex    = stall | branch_taken_f_ex | ~in_run;
      halted         = (state_q == HALTED);
      stall_cnt      = cnt_q;
   end

   // Stage boundary: scoreboard shift, FSM and counter registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= RUN;
         ex_q.vld  <= 1'b0;
         mem_q.vld <= 1'b0;
         wb_q.vld  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q <= state_d;
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_FWD_EN
   localparam int RAW_ST = 0, LU_ST = 1, ALU_ST = 0;
`else
   localparam int RAW_ST = 3, LU_ST = 3, ALU_ST = 3;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   inst;
   logic          iv, br;
   logic          pc_hold, ifid_hold, flush, bubble, halted;
   logic [CW-1:0] stall_cnt;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(CW), .NREG_W(5)) dut (
      .clk(clk), .reset(reset), .inst_f_if(inst), .inst_valid_f_if(iv),
      .branch_taken_f_ex(br), .pc_hold_2_if(pc_hold), .ifid_hold_2_if(ifid_hold),
      .flush_2_if(flush), .bubble_2_ex(bubble), .halted(halted),
      .stall_cnt(stall_cnt));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc(input int op, input int rs, input int rt, input int rd);
      logic [31:0] w;
      w = '0;
      w[31:26] = op[5:0];
      w[25:21] = rs[4:0];
      w[20:16] = rt[4:0];
      w[15:11] = rd[4:0];
      return w;
   endfunction

   // ---------------- reference model ----------------
   // In-flight writers, index 0 = EX, 1 = MEM, 2 = WB. mst: 0 run, 1 drain, 2 halted.
   bit       m_init = 0;
   bit       sv[3];
   bit [4:0] sd[3];
   bit       sl[3];
   int       mst, mcnt;

   function automatic void dest_of(input logic [31:0] i, output bit [4:0] d, output bit ld);
      int op;
      op = int'(i[31:26]);
      d = 0; ld = 0;
      if (op <= 11) d = op[0] ? i[20:16] : i[15:11];
      else if (op == 12) begin d = i[20:16]; ld = 1; end
   endfunction

   function automatic void model_now(output bit e_stall, output bit e_issue);
      int op;
      bit [4:0] srcs[$];
      bit hit;
      op = int'(inst[31:26]);
      if (op <= 11) begin srcs.push_back(inst[25:21]); if (!op[0]) srcs.push_back(inst[20:16]); end
      else if (op == 12 || op == 14 || op == 16) srcs.push_back(inst[25:21]);
      else if (op == 13 || op == 15) begin srcs.push_back(inst[25:21]); srcs.push_back(inst[20:16]); end
      hit = 0;
      foreach (srcs[k])
         if (srcs[k] != 0)
            for (int s = 0; s < 3; s++) begin
`ifdef HAZARD_FWD_EN
               if (s == 0 && sl[0] && sv[0] && sd[0] == srcs[k]) hit = 1;
`else
               if (sv[s] && sd[s] == srcs[k]) hit = 1;
`endif
            end
      e_stall = iv && mst == 0 && hit && !br;
      e_issue = iv && mst == 0 && !hit && !br;
   endfunction

   always @(posedge clk) begin
      bit e_stall, e_issue, ld;
      bit [4:0] d;
      if (!reset) begin
         m_init = 1;
         for (int s = 0; s < 3; s++) begin sv[s] = 0; sd[s] = 0; sl[s] = 0; end
         mst = 0; mcnt = 0;
      end else if (m_init) begin
         model_now(e_stall, e_issue);
         dest_of(inst, d, ld);
         if (e_stall && mcnt < CMAX) mcnt++;
         if (mst == 0 && e_issue && inst[31:26] == 6'h11) mst = 1;
         else if (mst == 1 && !sv[0] && !sv[1]) mst = 2;
         for (int s = 2; s > 0; s--) begin sv[s] = sv[s-1]; sd[s] = sd[s-1]; sl[s] = sl[s-1]; end
         sv[0] = e_issue && d != 0;
         sd[0] = d;
         sl[0] = ld;
      end
   end

   // Compare process: outputs are stable mid-cycle
   always @(negedge clk) begin
      bit e_stall, e_issue, run;
      if (m_init) begin
         model_now(e_stall, e_issue);
         run = (mst == 0);
         chk("pc_hold",   pc_hold,   e_stall || !run);
         chk("ifid_hold", ifid_hold, e_stall || !run);
         chk("flush",     flush,     br);
         chk("bubble",    bubble,    e_stall || br || !run);
         chk("halted",    halted,    mst == 2);
         chk("stall_cnt", stall_cnt, mcnt);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      iv = 0; br = 0;
      repeat (n) tick();
   endtask

   task automatic run_pair(input string nm, input logic [31:0] a, input logic [31:0] b, input int exp);
      int n;
      idle(3);
      inst = a; iv = 1; tick();
      inst = b; n = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (!pc_hold) break;
         n++;
         tick();
      end
      tick();
      iv = 0;
      chk(nm, n, exp);
   endtask

   initial begin
      logic [CW-1:0] c0;
      int d;
      reset = 0; inst = '0; iv = 0; br = 0;
      tick();
      repeat (3) begin
         inst = $urandom; iv = 1'($urandom);
         @(negedge clk);
         chk("rst_pc_hold", pc_hold, 0);
         chk("rst_bubble", bubble, 0);
         chk("rst_flush", flush, 0);
         chk("rst_halted", halted, 0);
         chk("rst_cnt", stall_cnt, 0);
         tick();
      end
      reset = 1;
      inst = enc(0, 3, 5, 4); iv = 1;
      @(negedge clk);
      chk("sb_empty", pc_hold, 0);
      tick();

      run_pair("raw_add", enc(0, 1, 2, 3), enc(0, 3, 5, 4), RAW_ST);
      chk("raw_cnt", stall_cnt, RAW_ST);
      run_pair("load_use", enc(12, 1, 7, 0), enc(1, 7, 8, 0), LU_ST);
      run_pair("alu_use", enc(0, 1, 2, 7), enc(1, 7, 8, 0), ALU_ST);
      run_pair("store_rt", enc(1, 1, 9, 0), enc(13, 2, 9, 0), ALU_ST);
      run_pair("r0_dest", enc(0, 1, 2, 0), enc(0, 0, 0, 4), 0);

      // Taken branch beats a RAW stall
      idle(3);
      inst = enc(0, 1, 2, 3); iv = 1; tick();
      inst = enc(0, 3, 5, 4); br = 1;
      @(negedge clk);
      c0 = stall_cnt;
      chk("br_flush", flush, 1);
      chk("br_bubble", bubble, 1);
      chk("br_nohold", pc_hold, 0);
      tick();
      chk("br_cnt_same", stall_cnt, c0);
      br = 0; iv = 0;

      // Saturation of the stall counter
      repeat (16) run_pair("lu_rep", enc(12, 1, 7, 0), enc(1, 7, 8, 0), LU_ST);
      chk("cnt_sat", stall_cnt, CMAX);

      // HALT with two writers ahead
      idle(3);
      inst = enc(0, 1, 2, 3); iv = 1; tick();
      inst = enc(0, 1, 2, 4); tick();
      inst = enc(17, 0, 0, 0); tick();
      iv = 0;
      d = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (halted) break;
         if (pc_hold) d++;
         tick();
      end
      chk("drain_cycles", d, 2);
      repeat (4) begin
         @(negedge clk);
         chk("halt_stays", halted, 1);
         chk("halt_hold", pc_hold, 1);
         tick();
      end

      // Reset mid-DRAIN
      reset = 0; tick(); reset = 1;
      idle(3);
      inst = enc(0, 1, 2, 3); iv = 1; tick();
      inst = enc(17, 0, 0, 0); tick();
      iv = 0;
      @(negedge clk);
      chk("in_drain", pc_hold, 1);
      reset = 0;
      tick();
      reset = 1;
      @(negedge clk);
      chk("rst_drain_halted", halted, 0);
      chk("rst_drain_hold", pc_hold, 0);
      tick();

      // Branch kills HALT
      idle(3);
      inst = enc(17, 0, 0, 0); iv = 1; br = 1; tick();
      iv = 0; br = 0;
      repeat (4) begin
         @(negedge clk);
         chk("bk_halted", halted, 0);
         chk("bk_hold", pc_hold, 0);
         tick();
      end

      // Random traffic against the model
      repeat (3000) begin
         reset = ($urandom_range(0, 149) != 0);
         if ($urandom_range(0, 199) == 0) inst = enc(17, 0, 0, 0);
         else inst = enc($urandom_range(0, 16), $urandom_range(0, 7),
                         $urandom_range(0, 7), $urandom_range(0, 7));
         iv = ($urandom_range(0, 3) != 0);
         br = ($urandom_range(0, 7) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
